nand4_out_monitor: RTL and testbench
====================================

Name: nand4_out_monitor

Overview:
- Downstream stage of the 4-input NAND gate primitive block (nand4_prim).
- Consumes the raw, asynchronous NAND output y and synchronises it to clk.
- Debounces it into a clean level, emits single-cycle edge pulses, and counts qualified low events (all four NAND inputs high) for readout.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on y_in (legal 2..4)
DEBOUNCE, 4, consecutive synchronised samples required to accept a level change (legal 1..255)
CNT_W, 8, width of the event counter and width measurement (legal 2..16)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
y_in  input  1  raw NAND output, asynchronous to clk
clr  input  1  synchronous clear of low_cnt and cnt_sat
y_filt  output  1  synchronised, debounced level of y_in
fall_pulse  output  1  one-cycle pulse when y_filt goes 1->0
rise_pulse  output  1  one-cycle pulse when y_filt goes 0->1
low_cnt  output  CNT_W  number of accepted falling events, saturating
cnt_sat  output  1  sticky flag; low_cnt has saturated
low_width  output  CNT_W  present only with PULSE_WIDTH_EN; length of the last low pulse, in cycles

Behaviour:
- Reset is asynchronous, while rst_n=0. All values are held until the first clk edge after release.
  - Synchroniser flops = 1 (the idle NAND output).
  - y_filt = 1.
  - fall_pulse = 0, rise_pulse = 0.
  - low_cnt = 0, cnt_sat = 0.
  - Debounce timer = 0.
  - State = STABLE_HI.
  - low_width = 0.
- Synchroniser: y_in passes through SYNC_STAGES flops; the last flop is sync_y. No other logic samples y_in.
- FSM states: STABLE_HI, QUAL_LO, STABLE_LO, QUAL_HI.
  - STABLE_HI: if sync_y=0, go to QUAL_LO with timer=1. If DEBOUNCE=1, go straight to STABLE_LO instead.
  - QUAL_LO: if sync_y=1, return to STABLE_HI with timer=0 (glitch rejected, no pulse). If timer reaches DEBOUNCE, go to STABLE_LO. Otherwise timer increments.
  - STABLE_LO and QUAL_HI mirror the above with polarities swapped.
- On entry to STABLE_LO: y_filt <= 0 and fall_pulse = 1 for exactly one cycle. On entry to STABLE_HI from QUAL_HI: y_filt <= 1 and rise_pulse = 1 for one cycle. Pulses are registered outputs.
- Latency: y_filt changes on rising edge number SYNC_STAGES+DEBOUNCE. Edge 1 is the first edge that samples the new y_in level. With defaults this is edge 6.
- Rejection: a sync_y excursion shorter than DEBOUNCE cycles produces no change on y_filt and no pulse.
- Counter:
  - low_cnt increments by 1 in the cycle fall_pulse is asserted.
  - When low_cnt is all-ones it holds, and cnt_sat sets and stays set.
- clr:
  - clr=1 sets low_cnt=0 and cnt_sat=0 on the next edge.
  - If clr and fall_pulse coincide, low_cnt=1 and cnt_sat=0; the event is not lost.
  - clr does not affect the FSM, y_filt or the pulses.
- rst_n asserted mid-qualification discards the pending change. After release the block restarts from STABLE_HI even if y_in=0, and requalifies from there.
- Constraint: the SYNC_STAGES and DEBOUNCE pipeline guarantees there is never more than one pulse per clock.

Optional Feature:
Macro PULSE_WIDTH_EN.
- Defined:
  - low_width port exists.
  - An internal width counter loads 1 on fall_pulse and increments each cycle while y_filt=0, saturating at all-ones.
  - On rise_pulse the counter value is copied into low_width, which holds until the next rise_pulse.
  - low_width is cleared by reset only; clr does not affect it.
- Undefined: the port, the width counter and the capture logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, y_in=1 held -> y_filt=1, no pulses, low_cnt=0 for 50 cycles; assert rst_n low mid-run -> all outputs return to reset values immediately, without waiting for a clock edge.
2. Defaults; y_in 1->0 settled before edge k -> fall_pulse high only during the cycle after edge k+5; y_filt=0 from edge k+5; low_cnt=1.
3. y_in low for 3 cycles then high (DEBOUNCE=4) -> no fall_pulse, y_filt stays 1, low_cnt=0; repeat with 4 cycles low -> pulse accepted.
4. CNT_W=2; 5 accepted low events -> low_cnt sequence 1,2,3,3,3; cnt_sat=1 after the 4th; clr -> low_cnt=0, cnt_sat=0; clr coincident with a fall_pulse -> low_cnt=1.
5. PULSE_WIDTH_EN defined, defaults; y_in low for 20 cycles -> low_width=20 after rise_pulse; next pulse of 7 cycles -> low_width=7; without the macro the build has no low_width port.
6. Drive y_in from $random sampled against nand4_prim's a,b,c,d -> low_cnt equals the reference model count of all-ones input vectors held at least SYNC_STAGES+DEBOUNCE cycles.

Source files
------------

// File: rtl/nand4_out_monitor.sv
// nand4_out_monitor: synchronises, debounces and edge-detects a raw NAND output and counts accepted low events.
// Define PULSE_WIDTH_EN to add the low_width output (length of the last accepted low pulse).
module nand4_out_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             y_in,
  input  logic             clr,
  output logic             y_filt,
  output logic             fall_pulse,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] low_cnt,
  output logic             cnt_sat
`ifdef PULSE_WIDTH_EN
  ,
  output logic [CNT_W-1:0] low_width
`endif
);
  typedef enum logic [1:0] {STABLE_HI, QUAL_LO, STABLE_LO, QUAL_HI} state_t;
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic sync_y;
  state_t state, state_nx;
  logic [7:0] timer, timer_nx;
  logic fall_nx, rise_nx;
  assign sync_y = sync[SYNC_STAGES-1];
  // Idle NAND output is high, so the chain resets to 1 to avoid a spurious fall.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '1;
    else sync <= {sync[SYNC_STAGES-2:0], y_in};
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    fall_nx = 1'b0;
    rise_nx = 1'b0;
    case (state)
      STABLE_HI: if (!sync_y) begin
        state_nx = DEBOUNCE == 1 ? STABLE_LO : QUAL_LO;
        timer_nx = DEBOUNCE == 1 ? 8'd0 : 8'd1;
        fall_nx = DEBOUNCE == 1;
      end
      QUAL_LO: if (sync_y) begin
        state_nx = STABLE_HI;
        timer_nx = 8'd0;
      end else if (timer == DB_LAST) begin
        state_nx = STABLE_LO;
        timer_nx = 8'd0;
        fall_nx = 1'b1;
      end else timer_nx = timer + 8'd1;
      STABLE_LO: if (sync_y) begin
        state_nx = DEBOUNCE == 1 ? STABLE_HI : QUAL_HI;
        timer_nx = DEBOUNCE == 1 ? 8'd0 : 8'd1;
        rise_nx = DEBOUNCE == 1;
      end
      default: if (!sync_y) begin
        state_nx = STABLE_LO;
        timer_nx = 8'd0;
      end else if (timer == DB_LAST) begin
        state_nx = STABLE_HI;
        timer_nx = 8'd0;
        rise_nx = 1'b1;
      end else timer_nx = timer + 8'd1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= STABLE_HI;
      timer <= 8'd0;
      y_filt <= 1'b1;
      fall_pulse <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      y_filt <= fall_nx ? 1'b0 : rise_nx ? 1'b1 : y_filt;
      fall_pulse <= fall_nx;
      rise_pulse <= rise_nx;
    end
  // A fall coinciding with clr is counted into the freshly cleared counter.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      low_cnt <= '0;
      cnt_sat <= 1'b0;
    end else if (clr) begin
      low_cnt <= CNT_W'(fall_pulse);
      cnt_sat <= 1'b0;
    end else if (fall_pulse) begin
      if (&low_cnt) cnt_sat <= 1'b1;
      else low_cnt <= low_cnt + 1'b1;
    end
`ifdef PULSE_WIDTH_EN
  logic [CNT_W-1:0] wcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt <= '0;
      low_width <= '0;
    end else begin
      if (fall_pulse) wcnt <= CNT_W'(1);
      else if (!y_filt && !(&wcnt)) wcnt <= wcnt + 1'b1;
      if (rise_pulse) low_width <= wcnt;
    end
`endif
endmodule

// File: tb/tb_nand4_out_monitor.sv
// tb_nand4_out_monitor: scoreboard bench for nand4_out_monitor (default DUT plus a CNT_W=2 DUT for saturation).
module tb_nand4_out_monitor;
  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE = 4;
  localparam int LAT = SYNC_STAGES + DEBOUNCE;
  logic clk = 1'b0, rst_n = 1'b0, y_in = 1'b1, clr = 1'b0, y2 = 1'b1, clr2 = 1'b0;
  logic y_filt, fall_pulse, rise_pulse, cnt_sat;
  logic [7:0] low_cnt;
  logic s_filt, s_fall, s_rise, s_sat;
  logic [1:0] s_cnt;
`ifdef PULSE_WIDTH_EN
  logic [7:0] low_width;
  logic [1:0] s_width;
`endif
  int errors = 0, checks = 0, exp_cnt = 0;
  int exp_q[$];
  bit cnt_due = 1'b0;

  always #5 clk = ~clk;

  nand4_out_monitor #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .clr(clr),
    .y_filt(y_filt), .fall_pulse(fall_pulse), .rise_pulse(rise_pulse),
    .low_cnt(low_cnt), .cnt_sat(cnt_sat)
`ifdef PULSE_WIDTH_EN
    , .low_width(low_width)
`endif
  );

  nand4_out_monitor #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .y_in(y2), .clr(clr2),
    .y_filt(s_filt), .fall_pulse(s_fall), .rise_pulse(s_rise),
    .low_cnt(s_cnt), .cnt_sat(s_sat)
`ifdef PULSE_WIDTH_EN
    , .low_width(s_width)
`endif
  );

  // One clock per call; low_cnt is compared against the queue the cycle after each fall_pulse.
  task automatic step;
    @(negedge clk);
    if (cnt_due) begin
      cnt_due = 1'b0;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_fall: low_cnt=%0d, no fall expected", low_cnt);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (low_cnt !== 8'(e)) begin
          errors++;
          $display("FAIL sb_low_cnt: got %0d, want %0d", low_cnt, e);
        end
      end
    end
    if (fall_pulse === 1'b1) cnt_due = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) step;
    checks++;
    if (y_filt !== 1'b1 || fall_pulse !== 1'b0 || rise_pulse !== 1'b0 || low_cnt !== 8'd0 || cnt_sat !== 1'b0 || s_rise !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: y_filt=%b fall=%b rise=%b low_cnt=%0d cnt_sat=%b, want 1 0 0 0 0", y_filt, fall_pulse, rise_pulse, low_cnt, cnt_sat);
    end
`ifdef PULSE_WIDTH_EN
    checks++;
    if (low_width !== 8'd0) begin
      errors++;
      $display("FAIL reset_low_width: got %0d, want 0", low_width);
    end
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step;
      checks++;
      if (y_filt !== 1'b1 || fall_pulse !== 1'b0 || rise_pulse !== 1'b0 || low_cnt !== 8'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d: y_filt=%b fall=%b rise=%b low_cnt=%0d, want 1 0 0 0", i, y_filt, fall_pulse, rise_pulse, low_cnt);
      end
    end
    y_in = 1'b0;
    exp_cnt++;
    exp_q.push_back(exp_cnt);
    repeat (8) step;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y_filt !== 1'b1 || fall_pulse !== 1'b0 || rise_pulse !== 1'b0 || low_cnt !== 8'd0 || cnt_sat !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: y_filt=%b fall=%b rise=%b low_cnt=%0d cnt_sat=%b, want 1 0 0 0 0", y_filt, fall_pulse, rise_pulse, low_cnt, cnt_sat);
    end
    exp_q.delete();
    exp_cnt = 0;
    cnt_due = 1'b0;
    repeat (2) step;
    rst_n = 1'b1;
    exp_cnt++;
    exp_q.push_back(exp_cnt);
    repeat (LAT - 1) step;
    checks++;
    if (y_filt !== 1'b1 || fall_pulse !== 1'b0) begin
      errors++;
      $display("FAIL restart_hold: y_filt=%b fall=%b, want 1 0", y_filt, fall_pulse);
    end
    step;
    checks++;
    if (y_filt !== 1'b0 || fall_pulse !== 1'b1) begin
      errors++;
      $display("FAIL restart_fall: y_filt=%b fall=%b, want 0 1", y_filt, fall_pulse);
    end
    y_in = 1'b1;
    repeat (12) step;
  endtask

  task automatic test_latency;
    y_in = 1'b0;
    exp_cnt++;
    exp_q.push_back(exp_cnt);
    repeat (LAT - 1) step;
    checks++;
    if (y_filt !== 1'b1 || fall_pulse !== 1'b0) begin
      errors++;
      $display("FAIL lat_before: y_filt=%b fall=%b, want 1 0", y_filt, fall_pulse);
    end
    step;
    checks++;
    if (y_filt !== 1'b0 || fall_pulse !== 1'b1) begin
      errors++;
      $display("FAIL lat_edge: y_filt=%b fall=%b, want 0 1", y_filt, fall_pulse);
    end
    step;
    checks++;
    if (y_filt !== 1'b0 || fall_pulse !== 1'b0 || low_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL lat_after: y_filt=%b fall=%b low_cnt=%0d, want 0 0 %0d", y_filt, fall_pulse, low_cnt, exp_cnt);
    end
    y_in = 1'b1;
    repeat (12) step;
    checks++;
    if (y_filt !== 1'b1) begin
      errors++;
      $display("FAIL lat_rise: y_filt=%b, want 1", y_filt);
    end
  endtask

  task automatic test_debounce;
    bit seen;
    y_in = 1'b0;
    repeat (DEBOUNCE - 1) step;
    y_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step;
      checks++;
      if (y_filt !== 1'b1 || fall_pulse !== 1'b0) begin
        errors++;
        $display("FAIL glitch_reject%0d: y_filt=%b fall=%b, want 1 0", i, y_filt, fall_pulse);
      end
    end
    checks++;
    if (low_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL glitch_cnt: low_cnt=%0d, want %0d", low_cnt, exp_cnt);
    end
    y_in = 1'b0;
    exp_cnt++;
    exp_q.push_back(exp_cnt);
    repeat (DEBOUNCE) step;
    y_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (fall_pulse === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || low_cnt !== 8'(exp_cnt) || y_filt !== 1'b1) begin
      errors++;
      $display("FAIL min_accept: seen=%b low_cnt=%0d y_filt=%b, want 1 %0d 1", seen, low_cnt, exp_cnt, y_filt);
    end
  endtask

  task automatic sat_event;
    y2 = 1'b0;
    repeat (8) step;
    y2 = 1'b1;
    repeat (10) step;
  endtask

  task automatic test_saturate;
    bit hit;
    for (int i = 1; i <= 5; i++) begin
      sat_event;
      checks++;
      if (s_cnt !== 2'(i > 3 ? 3 : i) || s_sat !== (i >= 4) || s_filt !== 1'b1) begin
        errors++;
        $display("FAIL sat_event%0d: low_cnt=%0d cnt_sat=%b y_filt=%b, want %0d %b 1", i, s_cnt, s_sat, s_filt, (i > 3 ? 3 : i), (i >= 4));
      end
    end
    clr2 = 1'b1;
    step;
    clr2 = 1'b0;
    checks++;
    if (s_cnt !== 2'd0 || s_sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr: low_cnt=%0d cnt_sat=%b, want 0 0", s_cnt, s_sat);
    end
    sat_event;
    sat_event;
    y2 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      step;
      hit = s_fall;
    end
    clr2 = hit;
    step;
    clr2 = 1'b0;
    checks++;
    if (!hit || s_cnt !== 2'd1 || s_sat !== 1'b0) begin
      errors++;
      $display("FAIL clr_coincident: seen=%b low_cnt=%0d cnt_sat=%b, want 1 1 0", hit, s_cnt, s_sat);
    end
    y2 = 1'b1;
    repeat (12) step;
  endtask

`ifdef PULSE_WIDTH_EN
  task automatic test_width;
    int lens[2] = '{20, 7};
    bit hit;
    foreach (lens[k]) begin
      y_in = 1'b0;
      exp_cnt++;
      exp_q.push_back(exp_cnt);
      repeat (lens[k]) step;
      y_in = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 12 && !hit; i++) begin
        step;
        hit = rise_pulse;
      end
      step;
      checks++;
      if (!hit || low_width !== 8'(lens[k])) begin
        errors++;
        $display("FAIL low_width_%0d: seen_rise=%b low_width=%0d, want 1 %0d", lens[k], hit, low_width, lens[k]);
      end
      repeat (6) step;
    end
  endtask
`endif

  task automatic test_random;
    logic a, b, c, d, all_hi;
    bit prev_low;
    int hold;
    prev_low = 1'b0;
    for (int n = 0; n < 120; n++) begin
      if (prev_low) {a, b, c, d} = 4'($urandom_range(0, 14));
      else {a, b, c, d} = 4'($urandom);
      all_hi = a & b & c & d;
      if (all_hi) hold = $urandom_range(0, 1) ? $urandom_range(1, DEBOUNCE - 1) : $urandom_range(LAT, LAT + 6);
      else hold = $urandom_range(DEBOUNCE, DEBOUNCE + 5);
      y_in = ~all_hi;
      if (all_hi && hold >= LAT) begin
        exp_cnt++;
        exp_q.push_back(exp_cnt);
      end
      repeat (hold) step;
      prev_low = all_hi;
    end
    y_in = 1'b1;
    repeat (12) step;
    checks++;
    if (low_cnt !== 8'(exp_cnt) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_total: low_cnt=%0d pending=%0d, want %0d 0", low_cnt, exp_q.size(), exp_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_debounce;
    test_saturate;
`ifdef PULSE_WIDTH_EN
    test_width;
`endif
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
